// File: rtl/speedgoal_ramp_if.sv
// Pushbutton/preset request and goal status bundle for speedgoal_ramp.
// master drives the requests; slave (the ramp) returns the goal and its status flags.
interface speedgoal_ramp_if #(
    parameter int WIDTH = 10
);
    logic                    clr;
    logic                    up;
    logic                    down;
    logic                    load;
    logic signed [WIDTH-1:0] load_val;
    logic signed [WIDTH-1:0] goal;
    logic                    at_max;
    logic                    at_min;
    logic                    changed;

    modport master (
        output clr, up, down, load, load_val,
        input  goal, at_max, at_min, changed
    );

    modport slave (
        input  clr, up, down, load, load_val,
        output goal, at_max, at_min, changed
    );
endinterface

// File: rtl/speedgoal_ramp.sv
// Signed, saturating setpoint generator driven by up/down buttons, with
// hold-to-repeat, acceleration after FAST_AFTER repeats, preset load and sync clear.
module speedgoal_ramp #(
    parameter int WIDTH         = 10,
    parameter int MIN_VAL       = -510,
    parameter int MAX_VAL       = 510,
    parameter int RESET_VAL     = 0,
    parameter int STEP          = 1,
    parameter int FAST_STEP     = 8,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int FAST_AFTER    = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    speedgoal_ramp_if.slave  bus
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int RW      = (FAST_AFTER < 1) ? 1 : $clog2(FAST_AFTER + 1);

    localparam logic signed [WIDTH:0] MIN_X   = (WIDTH+1)'(MIN_VAL);
    localparam logic signed [WIDTH:0] MAX_X   = (WIDTH+1)'(MAX_VAL);
    localparam logic signed [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);
    localparam logic signed [WIDTH:0] FAST_X  = (WIDTH+1)'(FAST_STEP);
    localparam logic [CW-1:0]         HOLD_END = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]         REP_END  = CW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0]         REP_SAT  = RW'(FAST_AFTER);
    localparam logic [RW-1:0]         REP_ONE  = (FAST_AFTER >= 1) ? RW'(1) : '0;
    localparam logic signed [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] goal_q, goal_d;
    logic                    changed_q, changed_d;
    logic                    dir_q, dir_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           rep_q, rep_d;

    logic          btn_any, btn_both, dir_valid;
    logic [CW-1:0] cnt_inc;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
        if (v > MAX_X)      return MAX_X[WIDTH-1:0];
        else if (v < MIN_X) return MIN_X[WIDTH-1:0];
        else                return v[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] step_goal(input logic signed [WIDTH-1:0] g,
                                                          input logic up_dir,
                                                          input logic fast);
        logic signed [WIDTH:0] ext;
        logic signed [WIDTH:0] s;
        ext = {g[WIDTH-1], g};
        s   = fast ? FAST_X : STEP_X;
        return sat(up_dir ? ext + s : ext - s);
    endfunction

    assign btn_any   = bus.up | bus.down;
    assign btn_both  = bus.up & bus.down;
    assign dir_valid = bus.up ^ bus.down;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        goal_d  = goal_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        if (bus.clr || bus.load) begin
            goal_d  = bus.clr ? RESET_W : sat({bus.load_val[WIDTH-1], bus.load_val});
            state_d = btn_any ? LOCK : IDLE;
            cnt_d   = '0;
            rep_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_both) begin
                        state_d = LOCK;
                    end else if (dir_valid) begin
                        goal_d  = step_goal(goal_q, bus.up, 1'b0);
                        dir_d   = bus.up;
                        cnt_d   = '0;
                        rep_d   = '0;
                        state_d = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (btn_both) begin
                        state_d = LOCK;
                    end else if (!btn_any) begin
                        state_d = IDLE;
                    end else if (bus.up != dir_q) begin
                        // Reversal while held behaves as a fresh press in the new direction.
                        goal_d  = step_goal(goal_q, bus.up, 1'b0);
                        dir_d   = bus.up;
                        cnt_d   = '0;
                        rep_d   = '0;
                        state_d = HOLD;
                    end else if (state_q == HOLD) begin
                        if (cnt_q == HOLD_END) begin
                            goal_d  = step_goal(goal_q, dir_q, 1'b0);
                            cnt_d   = '0;
                            rep_d   = REP_ONE;
                            state_d = REPEAT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        if (cnt_q == REP_END) begin
                            goal_d = step_goal(goal_q, dir_q, rep_q == REP_SAT);
                            cnt_d  = '0;
                            rep_d  = (rep_q == REP_SAT) ? rep_q : rep_q + RW'(1);
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                LOCK: begin
                    if (!btn_any) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        changed_d = (goal_d != goal_q);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            goal_q    <= RESET_W;
            changed_q <= 1'b0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            rep_q     <= '0;
        end else begin
            state_q   <= state_d;
            goal_q    <= goal_d;
            changed_q <= changed_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
        end
    end

    assign bus.goal    = goal_q;
    assign bus.changed = changed_q;
    assign bus.at_max  = (goal_q == MAX_X[WIDTH-1:0]);
    assign bus.at_min  = (goal_q == MIN_X[WIDTH-1:0]);

endmodule

// File: tb/tb_speedgoal_ramp.sv
// Bench for speedgoal_ramp: directed scenarios then randomized button/preset traffic,
// every edge checked against a press-age reference model.
module tb_speedgoal_ramp;
    localparam int W = 8, MINV = -20, MAXV = 20, RSTV = 0;
    localparam int ST = 1, FST = 4, H = 10, R = 4, FA = 3;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    speedgoal_ramp_if #(.WIDTH(W)) bus ();

    speedgoal_ramp #(
        .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV),
        .STEP(ST), .FAST_STEP(FST), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .FAST_AFTER(FA)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .bus(bus)
    );

    int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;

    // Reference: a press is characterised by its age t in edges since it began.
    int m_goal, m_pdir, m_t;
    bit m_changed, m_locked, m_pressing;
    int seg_len, pick;

    function automatic int clampi(int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_goal = RSTV; m_changed = 0; m_locked = 0; m_pressing = 0; m_t = 0; m_pdir = 0;
    endtask

    task automatic model_edge();
        int old, d, n;
        old = m_goal;
        if (bus.clr || bus.load) begin
            m_goal     = bus.clr ? RSTV : clampi(int'(bus.load_val));
            m_locked   = bus.up | bus.down;
            m_pressing = 0;
        end else if (m_locked) begin
            if (!bus.up && !bus.down) m_locked = 0;
        end else if (bus.up && bus.down) begin
            m_locked = 1; m_pressing = 0;
        end else if (!bus.up && !bus.down) begin
            m_pressing = 0;
        end else begin
            d = bus.up ? 1 : -1;
            if (!m_pressing || d != m_pdir) begin
                m_pressing = 1; m_pdir = d; m_t = 0;
                m_goal = clampi(m_goal + d * ST);
            end else begin
                m_t++;
                if (m_t >= H && (m_t - H) % R == 0) begin
                    n = (m_t - H) / R;
                    m_goal = clampi(m_goal + d * ((n >= FA) ? FST : ST));
                end
            end
        end
        m_changed = (m_goal != old);
    endtask

    task automatic check_all(string tag);
        chk({tag, "_goal"},    bus.goal, m_goal);
        chk({tag, "_changed"}, {31'b0, bus.changed}, m_changed);
        chk({tag, "_at_max"},  {31'b0, bus.at_max}, (m_goal == MAXV) ? 1 : 0);
        chk({tag, "_at_min"},  {31'b0, bus.at_min}, (m_goal == MINV) ? 1 : 0);
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic btn(bit u, bit d);
        bus.up = u; bus.down = d;
    endtask

    task automatic do_clr();
        bus.clr = 1; cyc("clr"); bus.clr = 0;
    endtask

    initial begin
        bus.clr = 0; bus.up = 0; bus.down = 0; bus.load = 0; bus.load_val = '0;
        #2 arst_n = 0;
        #1 model_reset();
        check_all("reset");
        @(negedge clk);
        arst_n = 1;
        cyc("idle");

        // 1: single press, then a 9-edge hold that stops short of the first repeat
        btn(1, 0); cyc("t1_press");
        chk("t1_goal1", bus.goal, 1);
        btn(0, 0); cyc("t1_rel");
        do_clr();
        btn(1, 0);
        for (int i = 0; i < 9; i++) cyc("t1_hold");
        chk("t1_hold_goal", bus.goal, 1);
        btn(0, 0); cyc("t1_rel2");

        // 2: long hold up into the fast phase and the upper bound
        do_clr();
        btn(1, 0);
        for (int i = 0; i <= 40; i++) begin
            cyc("t2_hold");
            if (i == 22) chk("t2_edge22", bus.goal, 8);
        end
        chk("t2_final", bus.goal, 20);
        chk("t2_atmax", {31'b0, bus.at_max}, 1);
        btn(0, 0); cyc("t2_rel");

        // 3: hold down from -18 into the lower bound, then a fresh up press
        bus.load = 1; bus.load_val = -8'sd18; cyc("t3_load"); bus.load = 0;
        btn(0, 1);
        for (int i = 0; i < 24; i++) cyc("t3_hold");
        chk("t3_atmin", {31'b0, bus.at_min}, 1);
        btn(0, 0); cyc("t3_rel");
        btn(1, 0); cyc("t3_up");
        chk("t3_up_goal", bus.goal, -19);
        btn(0, 0); cyc("t3_rel2");

        // 4: both buttons lock out stepping, from idle and mid-hold
        do_clr();
        btn(1, 1);
        for (int i = 0; i < 3; i++) cyc("t4_both");
        btn(0, 0); cyc("t4_rel");
        btn(0, 1); cyc("t4_down");
        chk("t4_down_goal", bus.goal, -1);
        btn(1, 0); cyc("t4_rev");
        cyc("t4_hold");
        btn(1, 1);
        for (int i = 0; i < 12; i++) cyc("t4_lock");
        btn(0, 1); cyc("t4_lock_down");
        btn(0, 0); cyc("t4_rel2");
        btn(0, 1); cyc("t4_down2");
        chk("t4_down2_goal", bus.goal, -1);
        btn(0, 0); cyc("t4_rel3");

        // 5: out-of-range load with up held, then clr and load together
        do_clr();
        btn(1, 0);
        bus.load = 1; bus.load_val = 8'sd100; cyc("t5_load"); bus.load = 0;
        chk("t5_clamped", bus.goal, 20);
        for (int i = 0; i < 5; i++) cyc("t5_locked");
        btn(0, 0); cyc("t5_rel");
        bus.clr = 1; bus.load = 1; bus.load_val = 8'sd5; cyc("t5_clr_load");
        bus.clr = 0; bus.load = 0;
        chk("t5_clr_wins", bus.goal, 0);

        // 6: asynchronous reset in the middle of a repeat phase
        btn(1, 0);
        for (int i = 0; i <= 27; i++) cyc("t6_hold");
        chk("t6_pre", bus.goal, 12);
        #3 arst_n = 0;
        #1 model_reset();
        check_all("t6_async");
        #2 arst_n = 1;
        cyc("t6_after");
        chk("t6_first", bus.goal, 1);
        btn(0, 0); cyc("t6_rel");

        // Randomized traffic
        for (int s = 0; s < 80; s++) begin
            pick = $urandom_range(0, 19);
            if (pick == 0) begin
                bus.clr = 1; cyc("rnd_clr"); bus.clr = 0;
            end else if (pick == 1) begin
                bus.load = 1; bus.load_val = W'($urandom_range(0, 255));
                cyc("rnd_load"); bus.load = 0;
            end else if (pick == 2) begin
                #3 arst_n = 0;
                #1 model_reset();
                check_all("rnd_async");
                #2 arst_n = 1;
            end else begin
                pick = $urandom_range(0, 9);
                btn(pick < 4 || pick == 8, (pick >= 4 && pick < 8) || pick == 8);
                seg_len = $urandom_range(1, 30);
                for (int i = 0; i < seg_len; i++) cyc("rnd_btn");
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
